// File: rtl/soc_reset_pkg.sv
// Shared types and defaults for the SoC reset sequencing logic.
package soc_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABLE     = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } rst_seq_state_t;

  localparam logic [7:0] LOCK_CNT_MAX = 8'hFF;

  localparam int DEFAULT_SYNC_STAGES           = 2;
  localparam int DEFAULT_LOCK_STABLE_CYCLES    = 1024;
  localparam int DEFAULT_PERIPH_TO_CORE_CYCLES = 16;
  localparam int DEFAULT_CNT_W                 = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous status bit; clears to 0 on reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: peripherals first, then core after a fixed gap.
module pll_reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int SYNC_STAGES           = DEFAULT_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES    = DEFAULT_LOCK_STABLE_CYCLES,
  parameter int PERIPH_TO_CORE_CYCLES = DEFAULT_PERIPH_TO_CORE_CYCLES,
  parameter int CNT_W                 = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_busy,
  output logic [7:0] lock_loss_cnt
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end
  if (LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_lock
    $error("LOCK_STABLE_CYCLES must be 1..2**CNT_W");
  end
  if (PERIPH_TO_CORE_CYCLES < 1 || longint'(PERIPH_TO_CORE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_core
    $error("PERIPH_TO_CORE_CYCLES must be 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(PERIPH_TO_CORE_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == LOCK_CNT_MAX) ? v : v + 8'd1;
  endfunction

  logic           locked_s;
  rst_seq_state_t state;
  logic [CNT_W-1:0] cnt;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Reset outputs are flops updated alongside the state, so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      periph_rst_n  <= 1'b0;
      core_rst_n    <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state        <= REL_PERIPH;
            cnt          <= '0;
            periph_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REL_PERIPH: begin
          if (!locked_s) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
          end else if (cnt == CORE_LAST) begin
            state      <= RUN;
            cnt        <= '0;
            core_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          // Lock loss wins over a coincident software request.
          if (!locked_s) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            periph_rst_n  <= 1'b0;
            core_rst_n    <= 1'b0;
            lock_loss_cnt <= sat_inc(lock_loss_cnt);
          end else if (sw_rst_req) begin
            state        <= STABLE;
            cnt          <= '0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
          end
        end
        default: begin
          state        <= WAIT_LOCK;
          cnt          <= '0;
          periph_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_busy = ~core_rst_n;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the raw `locked` output of the system PLL and produces staged, glitch-free, synchronously deasserted resets for the PLL output clock domain.
- Releases peripherals first, then the core after a fixed gap. Any lock loss or software reset request re-asserts both resets.
- Sits directly downstream of the PLL wrapper, clocked by its `outclk_0`.
- Feeds reset to the core, memory controller and peripherals.

Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchronizer; legal range 2..4.
- LOCK_STABLE_CYCLES, 1024: cycles locked_s must stay high before peripheral release; must be ≥ 1.
- PERIPH_TO_CORE_CYCLES, 16: cycles between periph_rst_n and core_rst_n release; must be ≥ 1.
- CNT_W, 16: width of the internal delay counter; must hold max(LOCK_STABLE_CYCLES, PERIPH_TO_CORE_CYCLES).

Ports:
- clk  in  1  PLL output clock (50 MHz).
- rst_n  in  1  Asynchronous active-low reset (board reset button).
- pll_locked  in  1  Raw PLL lock, asynchronous to clk.
- sw_rst_req  in  1  Synchronous single-cycle software reset request.
- periph_rst_n  out  1  Active-low peripheral reset, registered.
- core_rst_n  out  1  Active-low core reset, registered.
- rst_busy  out  1  High while the sequence is incomplete; equals !core_rst_n.
- lock_loss_cnt  out  8  Count of lock losses seen in RUN; saturates at 255.

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-low (clk / rst_n).
  - While rst_n=0: synchronizer flops=0, state=WAIT_LOCK, counter=0, periph_rst_n=0, core_rst_n=0, rst_busy=1, lock_loss_cnt=0.
  - rst_n assertion mid-sequence takes effect immediately, without waiting for a clock edge.
- Synchronizer
  - pll_locked passes through SYNC_STAGES flops to give locked_s.
  - No other logic samples pll_locked directly.
- States: WAIT_LOCK, STABLE, REL_PERIPH, RUN. Outputs are a decode of the registered state, so there are no glitches.
  - periph_rst_n=1 only in REL_PERIPH or RUN.
  - core_rst_n=1 only in RUN.
- WAIT_LOCK
  - If locked_s=1: go to STABLE, counter=0.
  - Otherwise stay.
- STABLE
  - If locked_s=0: go to WAIT_LOCK, counter=0.
  - Else if counter==LOCK_STABLE_CYCLES-1: go to REL_PERIPH, counter=0.
  - Else counter+1.
- REL_PERIPH
  - If locked_s=0: go to WAIT_LOCK. Both resets assert; lock_loss_cnt is not incremented.
  - Else if counter==PERIPH_TO_CORE_CYCLES-1: go to RUN.
  - Else counter+1.
- RUN
  - If locked_s=0: go to WAIT_LOCK and increment lock_loss_cnt (saturating at 255, never wraps).
  - Else if sw_rst_req=1: go to STABLE, counter=0. Lock wait is skipped, but the full stability delay and staging re-run.
  - Lock loss has priority when both occur in the same cycle: one increment, next state WAIT_LOCK.
- sw_rst_req outside RUN is ignored.
- Latency
  - Let E be the first edge that samples pll_locked=1 (held high).
  - periph_rst_n rises at edge E+SYNC_STAGES+LOCK_STABLE_CYCLES.
  - core_rst_n rises PERIPH_TO_CORE_CYCLES edges later.
- Lock-drop latency: both resets fall SYNC_STAGES+1 edges after pll_locked falls.
- Counter width: compare counter at CNT_W bits. Elaboration fails if either cycle parameter exceeds 2^CNT_W.

Decomposition:
- Shared package (soc_reset_pkg)
  - State enum rst_seq_state_t {WAIT_LOCK, STABLE, REL_PERIPH, RUN}.
  - Constant LOCK_CNT_MAX=8'hFF.
  - Default cycle constants.
- One sub-module: bit_synchronizer (parameter STAGES, reset value 0, asynchronous active-low reset). It is reused elsewhere for other async status inputs.

Test Plan (override LOCK_STABLE_CYCLES=8, PERIPH_TO_CORE_CYCLES=4, SYNC_STAGES=2):
- Power-up: hold rst_n=0 for 5 cycles, release, raise pll_locked before edge E -> periph_rst_n rises at E+10, core_rst_n at E+14, rst_busy falls with core_rst_n, lock_loss_cnt=0.
- Lock glitch in STABLE: pll_locked high for 5 cycles, low for 2, then high -> no release until 8 full stable cycles after the re-lock is synchronized, then periph_rst_n rises and core_rst_n follows 4 edges later.
- Lock loss in RUN: drop pll_locked -> both resets 0 three edges later, lock_loss_cnt=1; re-lock -> full sequence repeats.
- sw_rst_req pulse in RUN -> both resets 0 next edge; periph_rst_n returns 9 edges later, core_rst_n 4 after that; lock_loss_cnt unchanged; a pulse during STABLE has no effect.
- Simultaneous sw_rst_req and synchronized lock loss in RUN -> state WAIT_LOCK, lock_loss_cnt increments by exactly 1. Separately, 260 loss events -> lock_loss_cnt stays at 255.
- Assert rst_n=0 asynchronously mid-REL_PERIPH -> periph_rst_n=0 before the next clk edge; all state cleared.
